// File: rtl/assert_collector_pkg.sv
// Shared types and helpers for the assertion-failure collector.
package assert_collector_pkg;

    // Run-time assertion control opcodes ($asserton/$assertoff/$assertkill).
    typedef enum logic [1:0] {
        NOP  = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        KILL = 2'd3
    } ctl_op_e;

    // Widest report record any collector instance can emit (32 sites, 32-bit seq).
    // Each instance stores an exact-width copy of this record.
    localparam int SITE_W_MAX = 5;
    localparam int SEQ_W_MAX  = 32;

    typedef struct packed {
        logic [SITE_W_MAX-1:0] site;
        logic [SEQ_W_MAX-1:0]  seq;
    } report_t;

    // Saturating add of inc to a w-bit counter held in the low bits of cnt.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                            input logic [31:0] inc,
                                            input int          w);
        logic [32:0] lim;
        logic [32:0] sum;
        lim = (33'd1 << w) - 33'd1;
        sum = {1'b0, cnt} + {1'b0, inc};
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/assert_rr_arbiter.sv
// Round-robin arbiter: searches req starting at ptr, returns one-hot grant and index.
module assert_rr_arbiter #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_vld
);

    // First requester at or after ptr (wrapping) wins; nothing granted when en is low.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !gnt_vld && req[idx]) begin
                gnt_vld     = 1'b1;
                gnt_idx     = SW'(idx);
                gnt_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/assert_fail_collector.sv
// Assertion-failure collector: per-site on/off/kill control, pending-bit
// coalescing, round-robin serialisation into a report FIFO.
// Optional feature macro: ASSERT_COLLECTOR_DROP_CNT_EN enables the drop counter.
module assert_fail_collector
    import assert_collector_pkg::*;
#(
    parameter int NUM_SITES  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ctl_valid,
    input  logic [1:0]                   ctl_op,
    input  logic [NUM_SITES-1:0]         ctl_mask,
    input  logic [NUM_SITES-1:0]         fail,
    output logic                         rpt_valid,
    input  logic                         rpt_ready,
    output logic [$clog2(NUM_SITES)-1:0] rpt_site,
    output logic [CNT_W-1:0]             rpt_seq,
    output logic [NUM_SITES-1:0]         site_en,
    output logic [CNT_W-1:0]             total_fail,
    output logic [CNT_W-1:0]             drop_cnt
);

    localparam int SW = $clog2(NUM_SITES);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [SW-1:0]    site;
        logic [CNT_W-1:0] seq;
    } rpt_entry_t;

    logic [NUM_SITES-1:0] en_nxt, kill_mask, acc, pend, gnt_oh;
    logic [SW-1:0]        rr_ptr, gnt_idx;
    logic                 gnt_vld;

    rpt_entry_t           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 full, empty, push, pop;
    logic [CNT_W-1:0]     seq;

    // Resolve this cycle's control command first; fails see the post-command enable.
    always_comb begin
        en_nxt    = site_en;
        kill_mask = '0;
        if (ctl_valid) begin
            case (ctl_op_e'(ctl_op))
                ON:   en_nxt = site_en | ctl_mask;
                OFF:  en_nxt = site_en & ~ctl_mask;
                KILL: begin
                    en_nxt    = site_en & ~ctl_mask;
                    kill_mask = ctl_mask;
                end
                default: ;
            endcase
        end
    end

    assign acc   = fail & en_nxt;
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = gnt_vld;
    assign pop   = !empty && rpt_ready;

    // Full uses registered occupancy, so a pop while full does not free a slot this cycle.
    assert_rr_arbiter #(.N(NUM_SITES), .SW(SW)) u_arb (
        .req     (pend),
        .en      (!full),
        .ptr     (rr_ptr),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Enable mask register.
    always_ff @(posedge clk) begin
        if (rst) site_en <= '1;
        else     site_en <= en_nxt;
    end

    // Pending bits and round-robin pointer; a same-cycle fail re-arms a granted site.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend   <= '0;
            rr_ptr <= '0;
        end else begin
            pend <= (pend & ~gnt_oh & ~kill_mask) | acc;
            if (gnt_vld)
                rr_ptr <= (gnt_idx == SW'(NUM_SITES-1)) ? '0 : gnt_idx + SW'(1);
        end
    end

    // Report storage; contents are qualified by occupancy so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{site: gnt_idx, seq: seq};
    end

    // FIFO pointers, occupancy and wrapping sequence number.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            seq    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                seq    <= seq + CNT_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign rpt_valid = !empty;
    assign rpt_site  = empty ? '0 : mem[rd_ptr].site;
    assign rpt_seq   = empty ? '0 : mem[rd_ptr].seq;

    // Accepted-failure counter, one count per accepted site, saturating.
    always_ff @(posedge clk) begin
        if (rst) total_fail <= '0;
        else     total_fail <= CNT_W'(sat_inc(32'(total_fail), 32'($countones(acc)), CNT_W));
    end

`ifdef ASSERT_COLLECTOR_DROP_CNT_EN
    logic [NUM_SITES-1:0] drop_mask;

    // A fail landing on a still-pending, ungranted site is folded away and counted.
    assign drop_mask = acc & pend & ~gnt_oh;

    // Coalesced-failure counter, saturating.
    always_ff @(posedge clk) begin
        if (rst) drop_cnt <= '0;
        else     drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), 32'($countones(drop_mask)), CNT_W));
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_assert_fail_collector.sv
// Self-checking bench for assert_fail_collector (8 sites, 4-deep FIFO, 4-bit counters).
module tb_assert_fail_collector;

    localparam int NS = 8;
    localparam int FD = 4;
    localparam int CW = 4;
`ifdef ASSERT_COLLECTOR_DROP_CNT_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ctl_valid;
    logic [1:0]    ctl_op;
    logic [NS-1:0] ctl_mask;
    logic [NS-1:0] fail;
    logic          rpt_valid;
    logic          rpt_ready;
    logic [2:0]    rpt_site;
    logic [CW-1:0] rpt_seq;
    logic [NS-1:0] site_en;
    logic [CW-1:0] total_fail;
    logic [CW-1:0] drop_cnt;

    assert_fail_collector #(.NUM_SITES(NS), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ctl_valid(ctl_valid), .ctl_op(ctl_op),
        .ctl_mask(ctl_mask), .fail(fail), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .rpt_site(rpt_site), .rpt_seq(rpt_seq),
        .site_en(site_en), .total_fail(total_fail), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    site;
        logic [CW-1:0] seq;
    } exp_t;

    typedef struct {
        logic          cv;
        logic [1:0]    op;
        logic [NS-1:0] mask;
        logic [NS-1:0] fl;
        logic [NS-1:0] exp_en;
        logic [CW-1:0] exp_tot;
        int            exp_site;
    } vec_t;

    exp_t          sbq[$];
    int            nvec = 0;
    int            nmis = 0;
    logic [CW-1:0] exp_seq;
    vec_t          tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rpt(input int site);
        exp_t e;
        e.site = 3'(site);
        e.seq  = exp_seq;
        sbq.push_back(e);
        exp_seq = exp_seq + CW'(1);
    endtask

    task automatic do_reset();
        rst = 1'b1; ctl_valid = 1'b0; ctl_op = 2'd0; ctl_mask = '0; fail = '0;
        tick();
        rst = 1'b0;
        sbq.delete();
        exp_seq = '0;
    endtask

    task automatic pulse(input logic [NS-1:0] m);
        fail = m;
        tick();
        fail = '0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sbq.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        chk("drain_complete", 32'(sbq.size()), 32'd0);
    endtask

    // Scoreboard: every handshake pops one expected report.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rpt_valid && rpt_ready) begin
                if (sbq.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected_report: got site %0d seq %0d expected none", rpt_site, rpt_seq);
                end else begin
                    e = sbq.pop_front();
                    chk("rpt_site", 32'(rpt_site), 32'(e.site));
                    chk("rpt_seq",  32'(rpt_seq),  32'(e.seq));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // cv, op, mask, fail, site_en after, total after, reported site (-1 none)
        tbl[0] = '{1'b1, 2'd2, 8'h0F, 8'h0F, 8'hF0, 4'd0, -1};
        tbl[1] = '{1'b1, 2'd1, 8'h01, 8'h01, 8'hF1, 4'd1,  0};
        tbl[2] = '{1'b1, 2'd0, 8'hFF, 8'h02, 8'hF1, 4'd1, -1};
        tbl[3] = '{1'b0, 2'd3, 8'hFF, 8'h10, 8'hF1, 4'd2,  4};
        tbl[4] = '{1'b1, 2'd3, 8'h80, 8'h80, 8'h71, 4'd2, -1};
        tbl[5] = '{1'b1, 2'd1, 8'h80, 8'h00, 8'hF1, 4'd2, -1};
        tbl[6] = '{1'b1, 2'd2, 8'h00, 8'h20, 8'hF1, 4'd3,  5};
        tbl[7] = '{1'b1, 2'd1, 8'hFF, 8'h00, 8'hFF, 4'd3, -1};

        rpt_ready = 1'b0;
        do_reset();
        chk("rst_site_en",   32'(site_en),    32'hFF);
        chk("rst_rpt_valid", 32'(rpt_valid),  32'd0);
        chk("rst_rpt_site",  32'(rpt_site),   32'd0);
        chk("rst_rpt_seq",   32'(rpt_seq),    32'd0);
        chk("rst_total",     32'(total_fail), 32'd0);
        chk("rst_drop",      32'(drop_cnt),   32'd0);

        // Single fail: two-cycle latency to rpt_valid.
        rpt_ready = 1'b1;
        expect_rpt(0);
        pulse(8'h01);
        chk("lat_n1_valid", 32'(rpt_valid), 32'd0);
        tick();
        chk("lat_n2_valid", 32'(rpt_valid),  32'd1);
        chk("lat_total",    32'(total_fail), 32'd1);
        drain(5);
        tick();
        chk("single_idle", 32'(rpt_valid), 32'd0);

        // All sites at once with ready high: ordered burst, then idle.
        do_reset();
        rpt_ready = 1'b1;
        for (int i = 0; i < NS; i++) expect_rpt(i);
        pulse(8'hFF);
        drain(20);
        tick();
        chk("burst_idle",  32'(rpt_valid),  32'd0);
        chk("burst_total", 32'(total_fail), 32'd8);

        // Backpressure: FIFO fills with 0..3, head stable, 4..7 follow once released.
        do_reset();
        rpt_ready = 1'b0;
        pulse(8'hFF);
        repeat (6) tick();
        chk("bp_valid", 32'(rpt_valid), 32'd1);
        chk("bp_site",  32'(rpt_site),  32'd0);
        chk("bp_seq",   32'(rpt_seq),   32'd0);
        tick();
        chk("bp_site_stable", 32'(rpt_site), 32'd0);
        chk("bp_seq_stable",  32'(rpt_seq),  32'd0);
        for (int i = 0; i < NS; i++) expect_rpt(i);
        rpt_ready = 1'b1;
        drain(20);
        tick();
        chk("bp_idle", 32'(rpt_valid), 32'd0);

        // Control table: command and fail in the same cycle.
        do_reset();
        rpt_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            ctl_valid = tbl[v].cv;
            ctl_op    = tbl[v].op;
            ctl_mask  = tbl[v].mask;
            fail      = tbl[v].fl;
            if (tbl[v].exp_site >= 0) expect_rpt(tbl[v].exp_site);
            tick();
            ctl_valid = 1'b0; ctl_op = 2'd0; ctl_mask = '0; fail = '0;
            chk($sformatf("tbl%0d_site_en", v), 32'(site_en),    32'(tbl[v].exp_en));
            chk($sformatf("tbl%0d_total", v),   32'(total_fail), 32'(tbl[v].exp_tot));
            drain(6);
        end

        // KILL of a pending, blocked site: never reported, no drop.
        do_reset();
        rpt_ready = 1'b0;
        for (int i = 0; i < 4; i++) expect_rpt(i);
        pulse(8'h0F);
        repeat (4) tick();
        pulse(8'h20);
        ctl_valid = 1'b1; ctl_op = 2'd3; ctl_mask = 8'h20;
        tick();
        ctl_valid = 1'b0; ctl_op = 2'd0; ctl_mask = '0;
        chk("kill_site_en", 32'(site_en),    32'hDF);
        chk("kill_drop",    32'(drop_cnt),   32'd0);
        chk("kill_total",   32'(total_fail), 32'd5);
        rpt_ready = 1'b1;
        drain(10);
        repeat (8) tick();
        chk("kill_idle", 32'(rpt_valid), 32'd0);

        // Coalescing while blocked, then reset mid-burst.
        do_reset();
        rpt_ready = 1'b0;
        pulse(8'h0F);
        repeat (4) tick();
        pulse(8'h04);
        pulse(8'h04);
        chk("drop_cnt",   32'(drop_cnt),   32'(DROP_EN));
        chk("drop_total", 32'(total_fail), 32'd6);
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(rpt_valid),  32'd0);
        chk("midrst_total", 32'(total_fail), 32'd0);
        rst = 1'b0;
        sbq.delete();
        exp_seq = '0;
        rpt_ready = 1'b1;
        expect_rpt(3);
        pulse(8'h08);
        drain(6);

        // Counter saturation and sequence wrap with 4-bit counters.
        do_reset();
        rpt_ready = 1'b1;
        for (int i = 0; i < NS; i++) expect_rpt(i);
        pulse(8'hFF);
        drain(20);
        chk("sat_total8", 32'(total_fail), 32'd8);
        for (int i = 0; i < NS; i++) expect_rpt(i);
        pulse(8'hFF);
        drain(20);
        chk("sat_total15", 32'(total_fail), 32'd15);
        expect_rpt(0);
        pulse(8'h01);
        drain(6);
        chk("sat_hold", 32'(total_fail), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/assert_fail_collector.md
# assert_fail_collector

Synthesizable collector for immediate-assertion failures from up to NUM_SITES checker sites. It applies run-time assertion control (on/off/kill per site, the hardware analogue of $asserton/$assertoff/$assertkill) and coalesces failures into per-site pending bits. It serialises pending failures through a round-robin arbiter into a report FIFO drained by the downstream logger. It sits directly downstream of the assertion checker sites and upstream of the report/print stage.

## Interface
Parameters:
- NUM_SITES, 8, number of assertion sites (2..32)
- FIFO_DEPTH, 4, report FIFO entries (power of two, ≥2)
- CNT_W, 16, width of counters and sequence numbers

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- ctl_valid  in  1  control command strobe
- ctl_op  in  2  0=NOP, 1=ON, 2=OFF, 3=KILL
- ctl_mask  in  NUM_SITES  sites affected by command
- fail  in  NUM_SITES  single-cycle failure pulses, one per site
- rpt_valid  out  1  report available
- rpt_ready  in  1  downstream accepts report
- rpt_site  out  $clog2(NUM_SITES)  failing site index
- rpt_seq  out  CNT_W  report sequence number
- site_en  out  NUM_SITES  current enable mask
- total_fail  out  CNT_W  accepted failures, saturating
- drop_cnt  out  CNT_W  coalesced/discarded failures, saturating (macro-gated)

## Operation
- Reset values: site_en all ones; pend 0; FIFO empty; rpt_valid 0; rpt_site 0; rpt_seq 0; total_fail 0; drop_cnt 0; arbiter pointer 0.
- Control: ON sets site_en bits in ctl_mask. OFF clears them, and pending bits are kept. KILL clears them and also clears the matching pend bits. NOP and ctl_valid=0 make no change.
- Accept rule: fail[i] is accepted when the effective enable is 1. The effective enable is the site_en value after this cycle's command, so a command and a fail in the same cycle resolve control first.
- An accepted fail sets pend[i] and increments total_fail.
- If pend[i] is already set and is not being granted this cycle, the fail is coalesced and drop_cnt increments.
- A KILL that clears pend bits adds nothing to drop_cnt.
- Arbitration: when pend≠0 and the FIFO is not full, one site is granted per cycle.
  - Round-robin starts at the pointer; the pointer moves to grant+1 mod NUM_SITES.
  - The granted pend bit clears. A fail on that same site in the same cycle re-sets it and is not a drop.
  - The push carries {site, seq}; seq is a CNT_W counter that wraps.
- FIFO full: no grant; pend holds and the pointer holds.
- Output: rpt_valid = FIFO not empty. rpt_site and rpt_seq show the head entry. A pop happens when rpt_valid && rpt_ready.
- Simultaneous push and pop while full: the push is blocked for that cycle (the full check uses registered state).
- Counters saturate at all ones; rpt_seq wraps from 2^CNT_W−1 to 0.
- rst mid-operation discards pend and FIFO contents; the first report after reset has seq 0.

## Timing
- Fail pulse in cycle N → pend visible in N+1 → FIFO write at end of N+1 → rpt_valid in N+2 (empty FIFO, ready irrelevant). Latency is 2 cycles.
- Control command in cycle N → site_en updated in N+1.
- Throughput is one report per cycle with rpt_ready held high.
- rpt_* stay stable while rpt_valid && !rpt_ready.

## Configuration
- ASSERT_COLLECTOR_DROP_CNT_EN defined: drop_cnt logic is present as specified.
- Undefined: the drop_cnt port remains and is tied to 0, and no counter is instantiated.

## Structure
- Package assert_collector_pkg:
  - ctl_op_e enum {NOP, ON, OFF, KILL}
  - report struct {site, seq}
  - saturating-increment function
- Sub-module assert_rr_arbiter: NUM_SITES-wide request, pointer, one-hot grant plus index.
- FIFO is inline register-array logic in the top.

## Test plan
- Reset, then fail=8'h01 for one cycle → rpt_valid two cycles later, rpt_site=0, rpt_seq=0, total_fail=1.
- fail=8'hFF one cycle, rpt_ready=1 → eight reports with sites 0..7 in order, seq 0..7, and rpt_valid drops after the 8th.
- rpt_ready=0, fail=8'hFF → FIFO holds 4 entries (sites 0..3); pend holds 8'hF0; then ready=1 → sites 4..7 follow with seq 4..7.
- ctl OFF mask 8'h0F with fail=8'h0F in the same cycle → no reports, total_fail=0. Then ON mask 8'h01 and fail 8'h01 in the same cycle → one report, site 0.
- rpt_ready=0, fill FIFO with sites 0..3, pend site 5 set, then KILL mask 8'h20 → site 5 is never reported, drop_cnt unchanged, site_en=8'hDF.
- fail[2] twice while pend[2] is blocked (FIFO full) → drop_cnt=1 with the macro defined and 0 without; assert rst mid-burst → rpt_valid=0 next cycle, next report seq=0.
